// File: rtl/axi_ad9652_delay_cal.sv
// IDELAY calibration sequencer for the AD9652 capture path: sweeps a common tap
// across all lanes, qualifies PN status per tap and loads the centre of the widest eye.
module axi_ad9652_delay_cal #(
  parameter int NUM_LANES     = 17,
  parameter int TAP_WIDTH     = 5,
  parameter int SETTLE_CYCLES = 64,
  parameter int CHECK_CYCLES  = 1024,
  parameter int MIN_EYE       = 3,
  parameter int DEFAULT_TAP   = 16
) (
  input  logic                           adc_clk,
  input  logic                           adc_rst,
  input  logic                           cal_start,
  input  logic                           cal_abort,
  input  logic [1:0]                     adc_pn_oos,
  input  logic [1:0]                     adc_pn_err,
  output logic                           adc_pn_mode_req,
  output logic [NUM_LANES-1:0]           delay_ld,
  output logic [NUM_LANES*TAP_WIDTH-1:0] delay_wdata,
  output logic                           cal_busy,
  output logic                           cal_done,
  output logic                           cal_fail,
  output logic [TAP_WIDTH-1:0]           cal_tap,
  output logic [TAP_WIDTH:0]             cal_eye_len
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_APPLY  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [TAP_WIDTH-1:0] DEF_TAP     = TAP_WIDTH'(DEFAULT_TAP);
  localparam logic [TAP_WIDTH:0]   LEN_ONE     = (TAP_WIDTH+1)'(1);
  localparam logic [TAP_WIDTH:0]   LEN_MIN     = (TAP_WIDTH+1)'(MIN_EYE);

  logic [2:0]                            r_state;
  logic [CNT_W-1:0]                      r_cnt;
  logic [TAP_WIDTH-1:0]                  r_tap, r_run_start, r_best_start, r_final;
  logic [TAP_WIDTH:0]                    r_run_len, r_best_len;
  logic                                  r_bad, r_ok, r_busy, r_done, r_fail;
  logic [NUM_LANES-1:0]                  r_ld;
  logic [NUM_LANES-1:0][TAP_WIDTH-1:0]   r_wdata;
  logic [TAP_WIDTH-1:0]                  r_cal_tap;
  logic [TAP_WIDTH:0]                    r_eye_len;

  logic                 w_pass, w_best_upd, w_ok, w_last_tap;
  logic [TAP_WIDTH:0]   w_run_nx, w_best_len_nx;
  logic [TAP_WIDTH-1:0] w_run_start_nx, w_best_start_nx, w_center, w_half, w_final;

  function automatic logic [NUM_LANES-1:0][TAP_WIDTH-1:0] rep(input logic [TAP_WIDTH-1:0] v);
    logic [NUM_LANES-1:0][TAP_WIDTH-1:0] o;
    for (int i = 0; i < NUM_LANES; i++) o[i] = v;
    return o;
  endfunction

  // Window bookkeeping for the tap being evaluated; the last tap's result must
  // feed the centre computation in the same cycle.
  assign w_pass          = !r_bad;
  assign w_run_nx        = w_pass ? (r_run_len + LEN_ONE) : '0;
  assign w_run_start_nx  = (w_pass && r_run_len == '0) ? r_tap : r_run_start;
  assign w_best_upd      = w_pass && (w_run_nx > r_best_len);
  assign w_best_len_nx   = w_best_upd ? w_run_nx : r_best_len;
  assign w_best_start_nx = w_best_upd ? w_run_start_nx : r_best_start;
  assign w_ok            = (w_best_len_nx >= LEN_MIN);
  assign w_half          = TAP_WIDTH'((w_best_len_nx - LEN_ONE) >> 1);
  assign w_center        = w_best_start_nx + w_half;
  assign w_final         = w_ok ? w_center : DEF_TAP;
  assign w_last_tap      = (r_tap == '1);

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tap        <= '0;
      r_run_start  <= '0;
      r_best_start <= '0;
      r_final      <= '0;
      r_run_len    <= '0;
      r_best_len   <= '0;
      r_bad        <= 1'b0;
      r_ok         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_ld         <= '0;
      r_wdata      <= '0;
      r_cal_tap    <= '0;
      r_eye_len    <= '0;
    end else begin
      r_ld <= '0;
      case (r_state)
        S_IDLE: begin
          if (cal_start && !cal_abort) begin
            r_tap        <= '0;
            r_run_len    <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b1;
            r_ld         <= '1;
            r_wdata      <= rep('0);
            r_state      <= S_LOAD;
          end
        end
        S_LOAD, S_SETTLE, S_CHECK, S_EVAL: begin
          if (cal_abort) begin
            r_final <= DEF_TAP;
            r_ok    <= 1'b0;
            r_ld    <= '1;
            r_wdata <= rep(DEF_TAP);
            r_state <= S_APPLY;
          end else if (r_state == S_LOAD) begin
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end else if (r_state == S_SETTLE) begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt   <= '0;
              r_bad   <= 1'b0;
              r_state <= S_CHECK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_state == S_CHECK) begin
            r_bad <= r_bad | (|adc_pn_oos) | (|adc_pn_err);
            if (r_cnt == CHECK_LAST) r_state <= S_EVAL;
            else                     r_cnt   <= r_cnt + 1'b1;
          end else begin
            r_run_len    <= w_run_nx;
            r_run_start  <= w_run_start_nx;
            r_best_len   <= w_best_len_nx;
            r_best_start <= w_best_start_nx;
            r_ld         <= '1;
            if (!w_last_tap) begin
              r_tap   <= r_tap + 1'b1;
              r_wdata <= rep(r_tap + 1'b1);
              r_state <= S_LOAD;
            end else begin
              r_final <= w_final;
              r_ok    <= w_ok;
              r_wdata <= rep(w_final);
              r_state <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          r_cal_tap <= r_final;
          r_eye_len <= r_best_len;
          r_done    <= r_ok;
          r_fail    <= !r_ok;
          r_busy    <= 1'b0;
          r_state   <= S_FINISH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adc_pn_mode_req = r_busy;
  assign cal_busy        = r_busy;
  assign cal_done        = r_done;
  assign cal_fail        = r_fail;
  assign delay_ld        = r_ld;
  assign delay_wdata     = r_wdata;
  assign cal_tap         = r_cal_tap;
  assign cal_eye_len     = r_eye_len;

endmodule
